pll_lock_supervisor: RTL and testbench

- Consumer side of the board PLL (85 MHz CLKOUT/LOCK pair), running in the PLL output clock domain.
- Synchronises the asynchronous LOCK flag and requires it to be stable before releasing system reset.
- Asserts reset again on loss of lock and counts lock-loss events for the UART test logic to report.

---
 rtl/pll_lock_supervisor.sv | 159 +++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: qualifies the asynchronous PLL LOCK flag in the PLL
// output clock domain, holds downstream logic in reset until lock has been
// stable, and re-asserts reset (counting the event) whenever lock is lost.
// Optional lock-acquisition timeout: define PLL_LOCK_SUPERVISOR_TIMEOUT_EN.
module pll_lock_supervisor #(
  parameter int STABLE_CYCLES     = 1024,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter int LOSS_COUNT_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES    = 1048576
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        pll_lock,
  input  logic                        clear_loss,
  output logic                        sys_reset_n,
  output logic                        ready,
  output logic                        lock_lost_pulse,
  output logic [LOSS_COUNT_WIDTH-1:0] loss_count,
  output logic                        lock_timeout
);

  localparam int CNT_MAX = (STABLE_CYCLES > RESET_HOLD_CYCLES) ? STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [LOSS_COUNT_WIDTH-1:0] LOSS_MAX = {LOSS_COUNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             lock_s1, lock_s;
  logic             loss_event;
  logic             enter_run;

  // Two-flop synchroniser bringing the asynchronous LOCK into the clk domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_s1 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      lock_s1 <= pll_lock;
      lock_s  <= lock_s1;
    end
  end

  // Qualification sequence: any drop of the synchronised lock restarts it
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    loss_event = 1'b0;
    unique case (state)
      WAIT_LOCK: begin
        cnt_next = '0;
        if (lock_s) state_next = STABLE;
      end
      STABLE: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_next = HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RUN: begin
        cnt_next = '0;
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          loss_event = 1'b1;
        end
      end
      default: begin
        state_next = WAIT_LOCK;
        cnt_next   = '0;
      end
    endcase
  end

  assign enter_run = (state_next == RUN) && (state != RUN);

  // State register plus registered reset/ready/pulse outputs driven from next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= WAIT_LOCK;
      cnt             <= '0;
      sys_reset_n     <= 1'b0;
      ready           <= 1'b0;
      lock_lost_pulse <= 1'b0;
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      sys_reset_n     <= (state_next == RUN);
      ready           <= (state_next == RUN);
      lock_lost_pulse <= loss_event;
    end
  end

  // Saturating loss counter; a clear coinciding with a loss keeps the new event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loss_count <= '0;
    end else if (clear_loss) begin
      loss_count <= loss_event ? LOSS_COUNT_WIDTH'(1) : '0;
    end else if (loss_event && (loss_count != LOSS_MAX)) begin
      loss_count <= loss_count + 1'b1;
    end
  end

`ifdef PLL_LOCK_SUPERVISOR_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_SAT  = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] wait_cnt;

  // Accumulate time spent waiting for lock; saturates one past the limit so the flag sets once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt     <= '0;
      lock_timeout <= 1'b0;
    end else begin
      if (enter_run) begin
        wait_cnt <= '0;
      end else if ((state == WAIT_LOCK) && (wait_cnt != TO_SAT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (clear_loss || enter_run) begin
        lock_timeout <= 1'b0;
      end else if ((state == WAIT_LOCK) && (wait_cnt == TO_LAST)) begin
        lock_timeout <= 1'b1;
      end
    end
  end
`else
  logic unused_enter_run;
  assign unused_enter_run = enter_run;
  assign lock_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: table-driven and randomized checks of the PLL lock
// supervisor against a run-length reference model.
// Timeout checks follow PLL_LOCK_SUPERVISOR_TIMEOUT_EN.
module tb_pll_lock_supervisor;

  localparam int S    = 4;
  localparam int H    = 2;
  localparam int LW   = 8;
  localparam int T    = 32;
  localparam int QUAL = 1 + S + H;
  localparam logic [LW-1:0] CNT_MAX = {LW{1'b1}};

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          pll_lock = 1'b1;
  logic          clear_loss = 1'b0;
  logic          sys_reset_n;
  logic          ready;
  logic          lock_lost_pulse;
  logic [LW-1:0] loss_count;
  logic          lock_timeout;

  int nChecks = 0;
  int nErrors = 0;

  pll_lock_supervisor #(
    .STABLE_CYCLES    (S),
    .RESET_HOLD_CYCLES(H),
    .LOSS_COUNT_WIDTH (LW),
    .TIMEOUT_CYCLES   (T)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pll_lock       (pll_lock),
    .clear_loss     (clear_loss),
    .sys_reset_n    (sys_reset_n),
    .ready          (ready),
    .lock_lost_pulse(lock_lost_pulse),
    .loss_count     (loss_count),
    .lock_timeout   (lock_timeout)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Reference model: the supervisor is in RUN once the synchronised lock has
  // been seen high for QUAL consecutive edges; a low seen after that is a loss
  logic          m_s1 = 1'b0;
  logic          m_s2 = 1'b0;
  int            m_run = 0;
  logic          m_ready = 1'b0;
  logic          m_pulse = 1'b0;
  logic [LW-1:0] m_count = '0;
  int            m_wait = 0;
  logic          m_to = 1'b0;

  // Advance the model on every clock edge or asynchronous reset
  always @(posedge clk or negedge reset_n) begin : model_step
    int   run_n;
    logic lost;
    logic entering;
    if (!reset_n) begin
      m_s1    <= 1'b0;
      m_s2    <= 1'b0;
      m_run   <= 0;
      m_ready <= 1'b0;
      m_pulse <= 1'b0;
      m_count <= '0;
      m_wait  <= 0;
      m_to    <= 1'b0;
    end else begin
      run_n    = m_s2 ? ((m_run < QUAL) ? m_run + 1 : QUAL) : 0;
      lost     = !m_s2 && (m_run >= QUAL);
      entering = (run_n >= QUAL) && (m_run < QUAL);
      m_s1    <= pll_lock;
      m_s2    <= m_s1;
      m_run   <= run_n;
      m_ready <= (run_n >= QUAL);
      m_pulse <= lost;
      if (clear_loss)
        m_count <= lost ? LW'(1) : '0;
      else if (lost && m_count != CNT_MAX)
        m_count <= m_count + 1'b1;
`ifdef PLL_LOCK_SUPERVISOR_TIMEOUT_EN
      if (entering)
        m_wait <= 0;
      else if (m_run == 0 && m_wait < T)
        m_wait <= m_wait + 1;
      if (clear_loss || entering)
        m_to <= 1'b0;
      else if (m_run == 0 && m_wait == T - 1)
        m_to <= 1'b1;
`else
      m_wait <= 0;
      m_to   <= 1'b0;
`endif
    end
  end

  task automatic checkOutput(input string name, input logic e_rn, input logic e_rdy,
                             input logic e_pulse, input logic [LW-1:0] e_cnt, input logic e_to);
    nChecks++;
    if ({sys_reset_n, ready, lock_lost_pulse, loss_count, lock_timeout} !==
        {e_rn, e_rdy, e_pulse, e_cnt, e_to}) begin
      nErrors++;
      $display("[TB] FAIL %s @%0t: got rn=%b rdy=%b pulse=%b cnt=%0d to=%b, expected rn=%b rdy=%b pulse=%b cnt=%0d to=%b",
               name, $time, sys_reset_n, ready, lock_lost_pulse, loss_count, lock_timeout,
               e_rn, e_rdy, e_pulse, e_cnt, e_to);
    end
  endtask

  // Drive inputs (caller sits just after a falling edge) and let n rising edges pass
  task automatic applyStimulus(input logic lock, input logic clr, input int n);
    pll_lock   = lock;
    clear_loss = clr;
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Continuous comparison against the reference model, away from the active edge
  always @(negedge clk) begin
    checkOutput("model", m_ready, m_ready, m_pulse, m_count, m_to);
  end

  typedef struct {
    logic          lock;
    logic          clr;
    int            cycles;
    logic          exp_rn;
    logic          exp_pulse;
    logic [LW-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 8, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 1'b0, 3, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 1'b0, 2, 1'b1, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 1'b0, 1, 1'b0, 1'b1, 8'd1};
    vecs[5]  = '{1'b0, 1'b0, 2, 1'b0, 1'b0, 8'd1};
    vecs[6]  = '{1'b1, 1'b0, 8, 1'b0, 1'b0, 8'd1};
    vecs[7]  = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 8'd1};
    vecs[8]  = '{1'b0, 1'b0, 3, 1'b0, 1'b1, 8'd2};
    vecs[9]  = '{1'b0, 1'b0, 2, 1'b0, 1'b0, 8'd2};
    vecs[10] = '{1'b1, 1'b0, 3, 1'b0, 1'b0, 8'd2};
    vecs[11] = '{1'b0, 1'b0, 1, 1'b0, 1'b0, 8'd2};
    vecs[12] = '{1'b1, 1'b0, 5, 1'b0, 1'b0, 8'd2};
    vecs[13] = '{1'b0, 1'b0, 1, 1'b0, 1'b0, 8'd2};
    vecs[14] = '{1'b1, 1'b0, 8, 1'b0, 1'b0, 8'd2};
    vecs[15] = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 8'd2};
    vecs[16] = '{1'b1, 1'b1, 1, 1'b1, 1'b0, 8'd0};
    vecs[17] = '{1'b1, 1'b0, 2, 1'b1, 1'b0, 8'd0};

    $display("[TB] reset and table vectors");
    repeat (2) @(negedge clk);
    checkOutput("reset_state", 1'b0, 1'b0, 1'b0, '0, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].lock, vecs[i].clr, vecs[i].cycles);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_rn, vecs[i].exp_rn,
                  vecs[i].exp_pulse, vecs[i].exp_cnt, 1'b0);
    end
    clear_loss = 1'b0;

    $display("[TB] loss counter saturation");
    pll_lock = 1'b1;
    doReset();
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 1'b0, 9);
      applyStimulus(1'b0, 1'b0, 3);
    end
    checkOutput("saturate", 1'b0, 1'b0, 1'b1, CNT_MAX, 1'b0);
    applyStimulus(1'b1, 1'b0, 9);
    checkOutput("sat_run", 1'b1, 1'b1, 1'b0, CNT_MAX, 1'b0);
    applyStimulus(1'b0, 1'b0, 2);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("clear_with_loss", 1'b0, 1'b0, 1'b1, 8'd1, 1'b0);
    clear_loss = 1'b0;

    $display("[TB] asynchronous reset during hold");
    applyStimulus(1'b1, 1'b0, 7);
    checkOutput("hold_state", 1'b0, 1'b0, 1'b0, 8'd1, 1'b0);
    #2 reset_n = 1'b0;
    #1 checkOutput("async_reset", 1'b0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 8);
    checkOutput("post_reset_8", 1'b0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("post_reset_9", 1'b1, 1'b1, 1'b0, '0, 1'b0);

    $display("[TB] lock timeout");
    pll_lock = 1'b0;
    doReset();
`ifdef PLL_LOCK_SUPERVISOR_TIMEOUT_EN
    applyStimulus(1'b0, 1'b0, T - 1);
    checkOutput("timeout_early", 1'b0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("timeout_set", 1'b0, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, 6);
    checkOutput("timeout_hold", 1'b0, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("timeout_run", 1'b1, 1'b1, 1'b0, '0, 1'b0);
`else
    applyStimulus(1'b0, 1'b0, T + 8);
    checkOutput("timeout_disabled", 1'b0, 1'b0, 1'b0, '0, 1'b0);
`endif

    $display("[TB] randomized lock activity");
    for (int i = 0; i < 300; i++) begin
      logic lvl;
      int   len;
      lvl = ($urandom_range(0, 99) < 60);
      len = lvl ? $urandom_range(1, 14) : $urandom_range(1, 6);
      if ($urandom_range(0, 7) == 0) begin
        applyStimulus(lvl, 1'b1, 1);
        if (len > 1) applyStimulus(lvl, 1'b0, len - 1);
      end else begin
        applyStimulus(lvl, 1'b0, len);
      end
    end
    clear_loss = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
